// File: rtl/spi_sensor_poller.sv
// Transaction sequencer for an ADXL345-style accelerometer behind an SPI master: init writes, then periodic X-axis reads.
// Optional motion detection (baseline + threshold strobe) is built when MOTION_DETECT_EN is defined.
module spi_sensor_poller #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned POLL_CYCLES    = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MOTION_THRESH  = 64
) (
  input  logic                       clk_system,
  input  logic                       reset_system,
  input  logic                       enable,
  input  logic                       clear_error,
  output logic                       start_transfer,
  output logic [REG_WIDTH-1:0]       data_inR,
  output logic [$clog2(REG_WIDTH):0] size_transfer,
  input  logic [REG_WIDTH-1:0]       data_outR,
  input  logic                       spi_cs,
  output logic [15:0]                sample,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       error,
  output logic                       alarm_trigger
);

  localparam int unsigned SIZE_W    = $clog2(REG_WIDTH) + 1;
  localparam int unsigned CNT_MAX_A = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > 8) ? CNT_MAX_A : 8;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);
  localparam int unsigned CS_WINDOW = 8;

  localparam logic [15:0] CMD_PWR  = 16'h2D08;
  localparam logic [15:0] CMD_FMT  = 16'h310B;
  localparam logic [15:0] CMD_RDLO = {1'b1, 1'b0, 6'h32, 8'h00};
  localparam logic [15:0] CMD_RDHI = {1'b1, 1'b0, 6'h33, 8'h00};

  typedef enum logic [3:0] {
    INIT_LOAD, INIT_WAIT, POLL_WAIT, RDLO_LOAD, RDLO_WAIT,
    RDHI_LOAD, RDHI_WAIT, PUBLISH, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               idx_q, idx_d;
  logic               seen_q, seen_d;
  logic [7:0]         lo_q, lo_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               start_d;
  logic [15:0]        sample_d;
  logic               valid_d;
  logic               busy_d;
  logic               error_d;
  logic [15:0]        new_s;
  logic               xfer_done;
  logic               xfer_fail;
  logic               unused_rx;

  assign size_transfer = SIZE_W'(16);
  assign data_inR      = {{(REG_WIDTH-16){1'b0}}, cmd_q};
  assign new_s         = {data_outR[7:0], lo_q};
  assign unused_rx     = ^data_outR[REG_WIDTH-1:8];

  // Completion is the first high cs after a low; failure is cs never dropping or the overall timeout.
  assign xfer_done = seen_q & spi_cs;
  assign xfer_fail = (!seen_q && spi_cs && (cnt_q == CNT_W'(CS_WINDOW-1)))
                   || (cnt_q == CNT_W'(TIMEOUT_CYCLES-1));

`ifdef MOTION_DETECT_EN
  logic [15:0] base_q, base_d;
  logic        base_v_q, base_v_d;
  logic        alarm_d;
  logic [16:0] diff;
  logic [16:0] dev;

  // Sign-extended 17-bit difference so the magnitude never overflows.
  assign diff = {new_s[15], new_s} - {base_q[15], base_q};
  assign dev  = diff[16] ? (~diff + 17'd1) : diff;
`else
  assign alarm_trigger = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    seen_d   = seen_q;
    lo_d     = lo_q;
    cmd_d    = cmd_q;
    start_d  = 1'b0;
    sample_d = sample;
    valid_d  = 1'b0;
`ifdef MOTION_DETECT_EN
    base_d   = base_q;
    base_v_d = base_v_q;
    alarm_d  = 1'b0;
`endif
    case (state_q)
      INIT_LOAD, RDLO_LOAD, RDHI_LOAD: begin
        start_d = 1'b1;
        cnt_d   = '0;
        seen_d  = 1'b0;
        case (state_q)
          INIT_LOAD: begin cmd_d = idx_q ? CMD_FMT : CMD_PWR; state_d = INIT_WAIT; end
          RDLO_LOAD: begin cmd_d = CMD_RDLO; state_d = RDLO_WAIT; end
          default:   begin cmd_d = CMD_RDHI; state_d = RDHI_WAIT; end
        endcase
      end
      INIT_WAIT, RDLO_WAIT, RDHI_WAIT: begin
        cnt_d  = cnt_q + CNT_W'(1);
        seen_d = seen_q | ~spi_cs;
        if (xfer_done) begin
          case (state_q)
            INIT_WAIT: begin
              if (idx_q) begin
                state_d = POLL_WAIT;
                cnt_d   = '0;
              end else begin
                idx_d   = 1'b1;
                state_d = INIT_LOAD;
              end
            end
            RDLO_WAIT: begin
              lo_d    = data_outR[7:0];
              state_d = RDHI_LOAD;
            end
            default: begin
              sample_d = new_s;
              valid_d  = 1'b1;
              state_d  = PUBLISH;
`ifdef MOTION_DETECT_EN
              if (!base_v_q) begin
                base_d   = new_s;
                base_v_d = 1'b1;
              end else begin
                alarm_d  = (dev > 17'(MOTION_THRESH));
              end
`endif
            end
          endcase
        end else if (xfer_fail) begin
          state_d = ERROR;
        end
      end
      POLL_WAIT: begin
        if (cnt_q == CNT_W'(POLL_CYCLES-1)) begin
          if (enable) state_d = RDLO_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PUBLISH: begin
        cnt_d   = '0;
        state_d = POLL_WAIT;
      end
      ERROR: begin
        if (clear_error) begin
          state_d  = INIT_LOAD;
          idx_d    = 1'b0;
`ifdef MOTION_DETECT_EN
          base_v_d = 1'b0;
`endif
        end
      end
      default: state_d = INIT_LOAD;
    endcase
    busy_d  = (state_d != POLL_WAIT) && (state_d != ERROR);
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk_system) begin
    if (!reset_system) begin
      state_q        <= INIT_LOAD;
      cnt_q          <= '0;
      idx_q          <= 1'b0;
      seen_q         <= 1'b0;
      lo_q           <= '0;
      cmd_q          <= '0;
      start_transfer <= 1'b0;
      sample         <= '0;
      sample_valid   <= 1'b0;
      busy           <= 1'b1;
      error          <= 1'b0;
`ifdef MOTION_DETECT_EN
      base_q         <= '0;
      base_v_q       <= 1'b0;
      alarm_trigger  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      seen_q         <= seen_d;
      lo_q           <= lo_d;
      cmd_q          <= cmd_d;
      start_transfer <= start_d;
      sample         <= sample_d;
      sample_valid   <= valid_d;
      busy           <= busy_d;
      error          <= error_d;
`ifdef MOTION_DETECT_EN
      base_q         <= base_d;
      base_v_q       <= base_v_d;
      alarm_trigger  <= alarm_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Scoreboard bench for spi_sensor_poller: behavioural SPI slave, expected-command and expected-sample queues.
module tb_spi_sensor_poller;
  localparam int unsigned RW     = 32;
  localparam int unsigned POLL   = 10;
  localparam int unsigned TMO    = 100;
  localparam int unsigned THRESH = 64;

  logic                      clk_system = 1'b0;
  logic                      reset_system = 1'b0;
  logic                      enable = 1'b0;
  logic                      clear_error = 1'b0;
  logic                      start_transfer;
  logic [RW-1:0]             data_inR;
  logic [$clog2(RW):0]       size_transfer;
  logic [RW-1:0]             data_outR = '0;
  logic                      spi_cs = 1'b1;
  logic [15:0]               sample;
  logic                      sample_valid;
  logic                      busy;
  logic                      error;
  logic                      alarm_trigger;

  spi_sensor_poller #(
    .REG_WIDTH(RW), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO), .MOTION_THRESH(THRESH)
  ) dut (
    .clk_system(clk_system), .reset_system(reset_system), .enable(enable),
    .clear_error(clear_error), .start_transfer(start_transfer), .data_inR(data_inR),
    .size_transfer(size_transfer), .data_outR(data_outR), .spi_cs(spi_cs),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .error(error),
    .alarm_trigger(alarm_trigger)
  );

  always #5 clk_system = ~clk_system;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk_system) cyc <= cyc + 1;

  logic [15:0] exp_cmd_q[$];
  logic [16:0] exp_s_q[$];
  logic [15:0] rx_q[$];
  int          n_starts = 0;
  int          last_start_cyc = -1;
  int          last_valid_cyc = -1;
  bit          hi_started = 0;
  bit          gap_mode = 0;
  bit          mute = 0;
  bit          prev_start = 0;
  bit          m_base_v = 0;
  int          m_base = 0;
  logic [15:0] last_s = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string nm, input int v, input int lo, input int hi);
    n_chk++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, v, lo, hi, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_system);
      #1;
    end
  endtask

  // Reference model: one poll = two read commands, one published sample, motion rule on plain integers.
  task automatic push_sample(input logic [15:0] s);
    logic a;
    a = 1'b0;
    rx_q.push_back(s);
    exp_cmd_q.push_back(16'hB200);
    exp_cmd_q.push_back(16'hB300);
`ifdef MOTION_DETECT_EN
    begin
      int d;
      if (!m_base_v) begin
        m_base   = int'($signed(s));
        m_base_v = 1;
      end else begin
        d = int'($signed(s)) - m_base;
        if (d < 0) d = -d;
        a = (d > int'(THRESH));
      end
    end
`endif
    last_s = s;
    exp_s_q.push_back({a, s});
  endtask

  function automatic logic [15:0] rnd_near(input int c);
    if ($urandom_range(0, 1) == 1) return 16'($urandom);
    return 16'(c + int'($urandom_range(0, 160)) - 80);
  endfunction

  task automatic expect_init();
    m_base_v = 0;
    exp_cmd_q.push_back(16'h2D08);
    exp_cmd_q.push_back(16'h310B);
  endtask

  task automatic wait_init(input string nm);
    for (int i = 0; i < 400 && (busy || exp_cmd_q.size() != 0); i++) tick();
    chk({nm, "_busy_low"}, 32'(busy), 0);
    chk({nm, "_error_low"}, 32'(error), 0);
    chk({nm, "_cmds_issued"}, exp_cmd_q.size(), 0);
  endtask

  // Monitor: pops expected TX words and samples whenever the DUT presents them.
  always @(negedge clk_system) begin
    if (reset_system) begin
      if (start_transfer) begin
        chk("start_single_cycle", 32'(prev_start), 0);
        if (gap_mode && last_valid_cyc > last_start_cyc)
          chk_range("poll_interval", cyc - last_valid_cyc, 10, 12);
        n_starts++;
        last_start_cyc = cyc;
        if (data_inR[15:0] == 16'hB300) hi_started = 1;
        if (exp_cmd_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_start: got cmd 0x%0h expected no transfer (t=%0t)", data_inR, $time);
        end else begin
          logic [15:0] e;
          e = exp_cmd_q.pop_front();
          chk("tx_word", data_inR, {16'h0000, e});
          chk("size_transfer", 32'(size_transfer), 32'd16);
        end
      end
      prev_start = start_transfer;
      if (sample_valid) begin
        last_valid_cyc = cyc;
        if (exp_s_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_sample: got 0x%0h expected no sample (t=%0t)", sample, $time);
        end else begin
          logic [16:0] es;
          es = exp_s_q.pop_front();
          chk("sample", 32'(sample), 32'(es[15:0]));
          chk("alarm_trigger", 32'(alarm_trigger), 32'(es[16]));
        end
      end else if (alarm_trigger) begin
        chk("alarm_with_valid", 32'(sample_valid), 1);
      end
    end else begin
      prev_start = 0;
    end
  end

  // SPI slave: lowers cs after a short delay, holds it 4..24 cycles, returns the requested byte.
  initial begin
    logic [15:0] cmd;
    logic [15:0] tmp;
    logic [7:0]  b;
    int          dly;
    int          len;
    forever begin
      @(negedge clk_system);
      if (reset_system && start_transfer && !mute) begin
        cmd = data_inR[15:0];
        b   = 8'($urandom);
        if (cmd == 16'hB200 && rx_q.size() > 0) begin
          tmp = rx_q[0];
          b   = tmp[7:0];
        end else if (cmd == 16'hB300 && rx_q.size() > 0) begin
          tmp = rx_q.pop_front();
          b   = tmp[15:8];
        end
        data_outR      = RW'($urandom);
        data_outR[7:0] = b;
        dly = int'($urandom_range(0, 3));
        len = int'($urandom_range(4, 24));
        for (int i = 0; i < dly && reset_system; i++) @(negedge clk_system);
        if (reset_system) spi_cs = 1'b0;
        for (int i = 0; i < len && reset_system; i++) @(negedge clk_system);
        spi_cs = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int en_cyc;
    int s_cyc;
    logic [15:0] s0;

    // Reset values
    repeat (3) @(posedge clk_system);
    #1;
    chk("rst_start", 32'(start_transfer), 0);
    chk("rst_data_inR", data_inR, 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_sample_valid", 32'(sample_valid), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_alarm", 32'(alarm_trigger), 0);
    chk("rst_busy", 32'(busy), 1);

    expect_init();
    @(negedge clk_system);
    reset_system = 1'b1;
    wait_init("init");

    // Polling disabled: no transfers
    n0 = n_starts;
    tick(50);
    chk("disabled_no_start", n_starts, n0);

    // Directed motion samples, then random ones
    push_sample(16'h0010);
    push_sample(16'h0040);
    push_sample(16'h0051);
    for (int i = 0; i < 15; i++) push_sample(rnd_near(16));
    n0 = n_starts;
    gap_mode = 1;
    enable = 1'b1;
    en_cyc = cyc;
    for (int i = 0; i < 10 && n_starts == n0; i++) tick();
    chk_range("enable_to_start", last_start_cyc - en_cyc, 1, 2);
    for (int i = 0; i < 3000 && exp_s_q.size() > 0; i++) tick();
    enable = 1'b0;
    gap_mode = 0;
    chk("samples_done", exp_s_q.size(), 0);
    tick(5);

    // Silent slave during RDLO: error after the cs window, no further starts
    mute = 1;
    exp_cmd_q.push_back(16'hB200);
    n0 = n_starts;
    enable = 1'b1;
    for (int i = 0; i < 20 && n_starts == n0; i++) tick();
    s_cyc = last_start_cyc;
    for (int i = 0; i < 30 && !error; i++) tick();
    chk("error_set", 32'(error), 1);
    chk_range("error_latency", cyc - s_cyc, 7, 9);
    chk("error_busy_low", 32'(busy), 0);
    n0 = n_starts;
    tick(20);
    chk("error_no_start", n_starts, n0);
    chk("error_sample_hold", 32'(sample), 32'(last_s));
    chk("error_held", 32'(error), 1);
    enable = 1'b0;
    mute = 0;
    expect_init();
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    wait_init("reinit");

    // clear_error outside ERROR has no effect
    n0 = n_starts;
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    tick(10);
    chk("clear_ignored_no_start", n_starts, n0);
    chk("clear_ignored_error", 32'(error), 0);

    // Reset during RDHI_WAIT
    rx_q.push_back(16'($urandom));
    exp_cmd_q.push_back(16'hB200);
    exp_cmd_q.push_back(16'hB300);
    hi_started = 0;
    enable = 1'b1;
    for (int i = 0; i < 200 && !hi_started; i++) tick();
    chk("rdhi_started", 32'(hi_started), 1);
    enable = 1'b0;
    tick();
    reset_system = 1'b0;
    @(posedge clk_system);
    #1;
    chk("midrst_start", 32'(start_transfer), 0);
    chk("midrst_data_inR", data_inR, 0);
    chk("midrst_sample", 32'(sample), 0);
    chk("midrst_sample_valid", 32'(sample_valid), 0);
    chk("midrst_error", 32'(error), 0);
    chk("midrst_alarm", 32'(alarm_trigger), 0);
    chk("midrst_busy", 32'(busy), 1);
    rx_q.delete();
    tick(2);
    expect_init();
    reset_system = 1'b1;
    wait_init("postrst_init");

    // Fresh baseline after reset, then random polls near it
    s0 = 16'($urandom);
    push_sample(s0);
    for (int i = 0; i < 6; i++) push_sample(rnd_near(int'($signed(s0))));
    gap_mode = 1;
    enable = 1'b1;
    for (int i = 0; i < 2000 && exp_s_q.size() > 0; i++) tick();
    enable = 1'b0;
    gap_mode = 0;
    tick(20);
    chk("final_cmd_queue_empty", exp_cmd_q.size(), 0);
    chk("final_sample_queue_empty", exp_s_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_sensor_poller.md
Name: spi_sensor_poller

Overview:
- Transaction sequencer directly upstream of the spi master. It issues the start_transfer pulses, TX words and transfer sizes, and consumes the received words.
- After reset it writes a fixed two-register init sequence to an ADXL345-style accelerometer. It then periodically reads the 16-bit X-axis sample as two 16-bit transfers and publishes it with a valid strike.
- Feeds the alarm logic with samples and, optionally, a motion trigger.

Parameters:
- REG_WIDTH, 32, width of spi master data_inR/data_outR.
- POLL_CYCLES, 50000, clk_system cycles between the end of one poll and the start of the next (minimum 2).
- TIMEOUT_CYCLES, 4096, maximum cycles from start_transfer until the transfer completes.
- MOTION_THRESH, 64, absolute deviation from the baseline that raises alarm_trigger (optional feature only).

Ports:
- clk_system  in  1  system clock
- reset_system  in  1  synchronous active-low reset
- enable  in  1  1 = polling allowed; sampled only in POLL_WAIT
- clear_error  in  1  one-cycle pulse; leaves ERROR state
- start_transfer  out  1  one-cycle pulse to the spi master
- data_inR  out  REG_WIDTH  TX word; command in [15:0], upper bits 0
- size_transfer  out  $clog2(REG_WIDTH)+1  always 16
- data_outR  in  REG_WIDTH  RX word; data byte in [7:0]
- spi_cs  in  1  spi master chip select, active-low
- sample  out  16  last X sample, {hi,lo}, two's complement
- sample_valid  out  1  one-cycle strobe when sample updates
- busy  out  1  high when state is not POLL_WAIT or ERROR
- error  out  1  high while in ERROR
- alarm_trigger  out  1  one-cycle motion strobe

Behaviour:
- Reset values, when reset_system=0 at a clk_system edge: state INIT_LOAD, init index 0, all counters 0, start_transfer=0, data_inR=0, sample=0, sample_valid=0, error=0, alarm_trigger=0, baseline invalid. Reset mid-transfer abandons the transfer immediately; the spi master is reset by the same signal.
- Init table: 16'h2D08 (POWER_CTL measure), then 16'h310B (DATA_FORMAT full-res ±16g).
- Read command: {1'b1, 1'b0, 6'h32} followed by 8'h00, which reads DATAX0. The HI read uses address 6'h33.
- Transfer handshake:
  - LOAD state: drive data_inR and pulse start_transfer for exactly 1 cycle, then enter the matching WAIT state. data_inR stays stable until the WAIT state exits.
  - WAIT state: a transfer is seen when spi_cs is low; it is complete on the first cycle spi_cs is high after having been seen low.
  - If spi_cs is not seen low within 8 cycles, or the transfer is not complete within TIMEOUT_CYCLES of the pulse, go to ERROR.
- State transitions:
  - INIT_LOAD -> INIT_WAIT -> (index 0: INIT_LOAD with index 1; index 1: POLL_WAIT with interval counter 0).
  - POLL_WAIT: counter increments each cycle. When counter = POLL_CYCLES-1 and enable=1, go to RDLO_LOAD. If enable=0, the counter saturates at POLL_CYCLES-1.
  - RDLO_LOAD -> RDLO_WAIT: on completion latch data_outR[7:0] as lo, then go to RDHI_LOAD -> RDHI_WAIT.
  - RDHI_WAIT completion: latch hi, go to PUBLISH.
  - PUBLISH (1 cycle): sample<={hi,lo}, sample_valid=1, counter reset to 0, go to POLL_WAIT.
  - ERROR: start_transfer=0, error=1. clear_error goes to INIT_LOAD with index 0, which re-runs init. sample holds its value.
- clear_error outside ERROR is ignored.
- If clear_error and a reset occur in the same cycle, reset wins.

Optional Feature:
- Macro: MOTION_DETECT_EN.
- When defined:
  - The first PUBLISH after init captures the baseline and does not trigger.
  - Each later PUBLISH computes |sample - baseline| with a 17-bit signed difference. If the result exceeds MOTION_THRESH, alarm_trigger pulses for 1 cycle, in the same cycle as sample_valid.
  - The baseline is not updated after capture. Leaving ERROR invalidates it.
- When undefined: alarm_trigger is tied to 0 and no baseline register exists.

Test Plan:
- Release reset with an spi model asserting cs low for 20 cycles after each start -> two transfers with data_inR[15:0] = 16'h2D08 then 16'h310B, size_transfer = 16, busy falls after the second completion.
- enable=1, POLL_CYCLES=10, model returns 8'h34 then 8'h12 -> data_inR = 16'hB200 then 16'hB300, sample = 16'h1234, one sample_valid pulse, next poll begins 10 cycles later.
- enable=0 in POLL_WAIT for 50 cycles -> no start_transfer. Raising enable -> start_transfer on the next cycle.
- Model never lowers cs after RDLO start -> error=1 at the 8th cycle, no further start pulses. clear_error -> init re-runs with 16'h2D08.
- reset_system low mid-RDHI_WAIT -> all outputs return to reset values on the next edge, and the 16'h2D08 transfer starts after release.
- MOTION_DETECT_EN: samples 16'h0010, 16'h0040, 16'h0051 -> alarm_trigger 0, 0, 1 (deviations 0, 48, 65 against threshold 64).
